// File: rtl/wb_trace_fifo_if.sv
// Bus bundle between the core write-back trace tap, the FWFT trace FIFO and its consumer.
// The master side drives write-backs and read acceptance; the slave side is the FIFO.
interface wb_trace_fifo_if #(
   parameter int AW = 3
);
   logic          wb_en;
   logic [7:0]    wb_pc;
   logic [7:0]    wb_data;
   logic          rd_ready;
   logic          rd_valid;
   logic [7:0]    rd_pc;
   logic [7:0]    rd_data;
   logic [AW:0]   count;
   logic          full;
   logic          overflow;
   logic [6:0]    dis1;
   logic [6:0]    dis2;

   modport master (
      output wb_en, wb_pc, wb_data, rd_ready,
      input  rd_valid, rd_pc, rd_data, count, full, overflow, dis1, dis2
   );

   modport slave (
      input  wb_en, wb_pc, wb_data, rd_ready,
      output rd_valid, rd_pc, rd_data, count, full, overflow, dis1, dis2
   );
endinterface

// File: rtl/wb_trace_fifo.sv
// First-word-fall-through FIFO capturing {PC, write-back data} pairs from the core,
// with a sticky overflow flag and the head data byte decoded onto two seven-segment digits.
module wb_trace_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic            i_clk,
   input  logic            i_rst,
   wb_trace_fifo_if.slave  bus
);
   localparam logic [AW:0] L_DEPTH = (AW+1)'(DEPTH);

   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          r_overflow;

   logic          w_valid;
   logic          w_full;
   logic          w_pop;
   logic          w_push;
   logic [15:0]   w_head;
   logic [3:0]    w_nib [2];
   logic [6:0]    w_seg [2];

   // Active-low {g,f,e,d,c,b,a} hex glyphs.
   function automatic logic [6:0] seg7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   assign w_valid = (r_count != '0);
   assign w_full  = (r_count == L_DEPTH);
   assign w_pop   = w_valid && bus.rd_ready;
   // A pop in the same cycle frees the slot, so a write-back at full is still accepted.
   assign w_push  = bus.wb_en && (!w_full || w_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         if (w_push && !w_pop)
            r_count <= r_count + (AW+1)'(1);
         else if (w_pop && !w_push)
            r_count <= r_count - (AW+1)'(1);
         if (bus.wb_en && !w_push)
            r_overflow <= 1'b1;
      end
   end

   // Storage has no reset: stale entries are never visible because RD_VALID gates the head.
   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wr_ptr] <= {bus.wb_pc, bus.wb_data};
   end

   assign w_head   = w_valid ? r_mem[r_rd_ptr] : 16'h0000;
   assign w_nib[0] = w_head[7:4];
   assign w_nib[1] = w_head[3:0];

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_digit
         assign w_seg[gi] = w_valid ? seg7(w_nib[gi]) : 7'h7F;
      end
   endgenerate

   assign bus.rd_valid = w_valid;
   assign bus.rd_pc    = w_head[15:8];
   assign bus.rd_data  = w_head[7:0];
   assign bus.count    = r_count;
   assign bus.full     = w_full;
   assign bus.overflow = r_overflow;
   assign bus.dis1     = w_seg[0];
   assign bus.dis2     = w_seg[1];
endmodule

// File: tb/tb_wb_trace_fifo.sv
// Self-checking bench for wb_trace_fifo: directed vector table, hand-written corner
// sequences, and randomized traffic compared against a queue-based reference model.
module tb_wb_trace_fifo;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   wb_trace_fifo_if #(.AW(3)) bus_if ();

   wb_trace_fifo #(.DEPTH(8), .AW(3)) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus_if.slave)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Active-high lit-segment patterns {g..a}; the display is the inverse of these.
   logic [6:0] lit_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   logic [15:0] mq [$];
   bit          m_ovf;

   typedef struct {
      logic       en;
      logic [7:0] pc;
      logic [7:0] data;
      logic       rdy;
      logic       ev;
      logic [7:0] ed;
      logic [3:0] ec;
      logic       ef;
      logic       eo;
   } vec_t;
   vec_t tab [$];

   function automatic vec_t mk(logic en, logic [7:0] pc, logic [7:0] data, logic rdy,
                               logic ev, logic [7:0] ed, int ec, logic ef, logic eo);
      vec_t v;
      v.en = en; v.pc = pc; v.data = data; v.rdy = rdy;
      v.ev = ev; v.ed = ed; v.ec = 4'(ec); v.ef = ef; v.eo = eo;
      return v;
   endfunction

   task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [6:0] seg_exp(logic [3:0] n);
      return ~lit_tab[n];
   endfunction

   // Reference model: a plain queue, updated with the inputs present at the edge.
   task automatic model_edge();
      bit pop, push;
      pop  = (mq.size() > 0) && bus_if.rd_ready;
      push = bus_if.wb_en && ((mq.size() < 8) || pop);
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back({bus_if.wb_pc, bus_if.wb_data});
      else if (bus_if.wb_en) m_ovf = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model(string tag);
      logic        v;
      logic [15:0] h;
      v = (mq.size() > 0);
      h = v ? mq[0] : 16'h0000;
      chk({tag, ".valid"}, 16'(bus_if.rd_valid), 16'(v));
      chk({tag, ".pc"},    16'(bus_if.rd_pc),    16'(h[15:8]));
      chk({tag, ".data"},  16'(bus_if.rd_data),  16'(h[7:0]));
      chk({tag, ".count"}, 16'(bus_if.count),    16'(mq.size()));
      chk({tag, ".full"},  16'(bus_if.full),     16'(mq.size() == 8));
      chk({tag, ".ovf"},   16'(bus_if.overflow), 16'(m_ovf));
      chk({tag, ".dis1"},  16'(bus_if.dis1),     16'(v ? seg_exp(h[7:4]) : 7'h7F));
      chk({tag, ".dis2"},  16'(bus_if.dis2),     16'(v ? seg_exp(h[3:0]) : 7'h7F));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      mq.delete();
      m_ovf = 1'b0;
      #3;
      rst = 1'b0;
      #1;
   endtask

   task automatic push_one(logic [7:0] pc, logic [7:0] data);
      bus_if.wb_en = 1'b1; bus_if.wb_pc = pc; bus_if.wb_data = data; bus_if.rd_ready = 1'b0;
      tick();
      bus_if.wb_en = 1'b0;
   endtask

   task automatic pop_expect(string nm, logic [7:0] data);
      chk(nm, 16'(bus_if.rd_data), 16'(data));
      bus_if.rd_ready = 1'b1;
      tick();
      bus_if.rd_ready = 1'b0;
      $display("pop %s: data=%02h", nm, data);
   endtask

   initial begin
      logic [7:0] seq5 [8];

      bus_if.wb_en = 1'b0; bus_if.wb_pc = '0; bus_if.wb_data = '0; bus_if.rd_ready = 1'b0;
      rst = 1'b1;
      m_ovf = 1'b0;

      // 1: reset held for three half-cycles, then released
      #16;
      chk("rst.count", 16'(bus_if.count), 16'h0);
      chk("rst.valid", 16'(bus_if.rd_valid), 16'h0);
      chk("rst.ovf",   16'(bus_if.overflow), 16'h0);
      chk("rst.dis1",  16'(bus_if.dis1), 16'h7F);
      chk("rst.dis2",  16'(bus_if.dis2), 16'h7F);
      rst = 1'b0;
      tick();
      check_model("rst_rel");

      // 2: single push visible right after its edge
      push_one(8'h04, 8'h5A);
      $display("push pc=04 data=5A");
      chk("p1.valid", 16'(bus_if.rd_valid), 16'h1);
      chk("p1.pc",    16'(bus_if.rd_pc),    16'h04);
      chk("p1.data",  16'(bus_if.rd_data),  16'h5A);
      chk("p1.count", 16'(bus_if.count),    16'h1);
      chk("p1.dis1",  16'(bus_if.dis1),     16'(7'b0010010));
      chk("p1.dis2",  16'(bus_if.dis2),     16'(7'b0001000));
      pop_expect("p1.pop", 8'h5A);
      chk("p1.empty", 16'(bus_if.rd_valid), 16'h0);

      // 3: fill + overflow, drain, empty-pop, push-with-ready on empty
      for (int i = 0; i < 9; i++)
         tab.push_back(mk(1'b1, 8'(i), 8'(i + 1), 1'b0, 1'b1, 8'h01,
                          (i < 8) ? i + 1 : 8, i >= 7, i == 8));
      for (int j = 0; j < 8; j++)
         tab.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, j < 7, (j < 7) ? 8'(j + 2) : 8'h00,
                          7 - j, 1'b0, 1'b1));
      tab.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1));
      tab.push_back(mk(1'b1, 8'hE0, 8'hC3, 1'b1, 1'b1, 8'hC3, 1, 1'b0, 1'b1));
      tab.push_back(mk(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1));
      for (int k = 0; k < tab.size(); k++) begin
         bus_if.wb_en = tab[k].en; bus_if.wb_pc = tab[k].pc;
         bus_if.wb_data = tab[k].data; bus_if.rd_ready = tab[k].rdy;
         tick();
         $display("vec %0d: en=%0b data=%02h rdy=%0b -> valid=%0b head=%02h count=%0d",
                  k, tab[k].en, tab[k].data, tab[k].rdy, bus_if.rd_valid, bus_if.rd_data,
                  bus_if.count);
         chk($sformatf("vec%0d.valid", k), 16'(bus_if.rd_valid), 16'(tab[k].ev));
         chk($sformatf("vec%0d.data", k),  16'(bus_if.rd_data),  16'(tab[k].ed));
         chk($sformatf("vec%0d.count", k), 16'(bus_if.count),    16'(tab[k].ec));
         chk($sformatf("vec%0d.full", k),  16'(bus_if.full),     16'(tab[k].ef));
         chk($sformatf("vec%0d.ovf", k),   16'(bus_if.overflow), 16'(tab[k].eo));
      end
      bus_if.wb_en = 1'b0; bus_if.rd_ready = 1'b0;

      // 4: wrap-around, order preserved across pointer wrap
      do_reset();
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 6; k++) push_one(8'(k), 8'(8'h10 + r * 6 + k));
         for (int k = 0; k < 6; k++)
            pop_expect($sformatf("wrap%0d_%0d", r, k), 8'(8'h10 + r * 6 + k));
      end
      chk("wrap.count", 16'(bus_if.count), 16'h0);
      check_model("wrap");

      // 5: simultaneous push and pop while full
      do_reset();
      for (int k = 0; k < 8; k++) push_one(8'(k), 8'(k + 1));
      chk("sim.full_before", 16'(bus_if.full), 16'h1);
      bus_if.wb_en = 1'b1; bus_if.wb_pc = 8'hF0; bus_if.wb_data = 8'hAA; bus_if.rd_ready = 1'b1;
      tick();
      bus_if.wb_en = 1'b0; bus_if.rd_ready = 1'b0;
      $display("push+pop at full: data=AA");
      chk("sim.count", 16'(bus_if.count),    16'h8);
      chk("sim.ovf",   16'(bus_if.overflow), 16'h0);
      chk("sim.head",  16'(bus_if.rd_data),  16'h02);
      seq5 = '{8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hAA};
      for (int k = 0; k < 8; k++) pop_expect($sformatf("sim_drain%0d", k), seq5[k]);
      check_model("sim_end");

      // 6: asynchronous reset between edges discards entries at once
      do_reset();
      for (int k = 0; k < 5; k++) push_one(8'(k), 8'(8'h61 + k));
      chk("ar.count5", 16'(bus_if.count), 16'h5);
      #2;
      rst = 1'b1;
      #1;
      $display("async reset asserted mid-cycle");
      chk("ar.valid", 16'(bus_if.rd_valid), 16'h0);
      chk("ar.count", 16'(bus_if.count),    16'h0);
      chk("ar.dis1",  16'(bus_if.dis1),     16'h7F);
      mq.delete();
      m_ovf = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_model("ar_hold");
      push_one(8'h33, 8'h77);
      chk("ar.head",  16'(bus_if.rd_data), 16'h77);
      chk("ar.pc",    16'(bus_if.rd_pc),   16'h33);
      chk("ar.count1", 16'(bus_if.count),  16'h1);

      // Randomized traffic against the queue model; ready bias alternates to reach full/empty
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         bus_if.wb_en    = ($urandom_range(0, 99) < 60);
         bus_if.wb_pc    = 8'($urandom);
         bus_if.wb_data  = 8'($urandom);
         bus_if.rd_ready = (((i / 150) % 2) != 0) ? ($urandom_range(0, 99) < 85)
                                                  : ($urandom_range(0, 99) < 25);
         tick();
         check_model($sformatf("rnd%0d", i));
      end
      $display("random phase: %0d cycles, final count=%0d", 1500, bus_if.count);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
